// File: rtl/hwaccel_pkg.sv
// Shared types and constants for the accelerator write-back paths.
package hwaccel_pkg;

  localparam int unsigned SHIFT_WIDTH = 5;
  localparam int          INT8_MAX    = 127;
  localparam int          INT8_MIN    = -128;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } wb_state_e;

endpackage

// File: rtl/requant_sat.sv
// Combinational requantizer: rounding arithmetic right-shift of a 32-bit
// accumulator followed by saturation to signed int8.
module requant_sat
  import hwaccel_pkg::*;
(
  input  logic [31:0]            value,
  input  logic [SHIFT_WIDTH-1:0] shift,
  output logic [7:0]             result,
  output logic                   saturated
);

  localparam logic signed [32:0] MaxVal = 33'(INT8_MAX);
  localparam logic signed [32:0] MinVal = 33'(INT8_MIN);

  logic signed [32:0] bias;
  logic signed [32:0] rounded;
  logic signed [32:0] shifted;

  always_comb begin
    bias = '0;
    if (shift != '0) begin
      bias = 33'sd1 <<< (shift - SHIFT_WIDTH'(1));
    end
    // 33 bits so that adding the rounding bias to INT32_MAX cannot overflow.
    rounded   = $signed({value[31], value}) + bias;
    shifted   = rounded >>> shift;
    result    = shifted[7:0];
    saturated = 1'b0;
    if (shifted > MaxVal) begin
      result    = 8'(INT8_MAX);
      saturated = 1'b1;
    end else if (shifted < MinVal) begin
      result    = 8'(INT8_MIN);
      saturated = 1'b1;
    end
  end

endmodule

// File: rtl/vec_writeback.sv
// Stream-to-SRAM result writer: requantizes the accumulator stream to int8 and
// writes it to consecutive vector SRAM addresses with a one-cycle write latency.
module vec_writeback
  import hwaccel_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_start,
  input  logic [SRAM_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [SRAM_ADDR_WIDTH-1:0] cfg_len,
  input  logic [SHIFT_WIDTH-1:0]     cfg_shift,
  input  logic [31:0]                in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       sram_we,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0]      sram_din,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                sat_count
);

  wb_state_e                  state_q, state_d;
  logic [SRAM_ADDR_WIDTH-1:0] remaining_q, remaining_d;
  logic [SRAM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [SHIFT_WIDTH-1:0]     shift_q, shift_d;
  logic                       we_q, we_d;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      din_q, din_d;
  logic [15:0]                sat_q, sat_d;

  logic       xfer;
  logic [7:0] rq_result;
  logic       rq_sat;

  requant_sat u_requant_sat (
    .value     (in_data),
    .shift     (shift_q),
    .result    (rq_result),
    .saturated (rq_sat)
  );

  assign in_ready  = (state_q == StRun) && (remaining_q != '0);
  assign xfer      = in_valid && in_ready;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign sram_we   = we_q;
  assign sram_addr = addr_q;
  assign sram_din  = din_q;
  assign sat_count = sat_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    wr_addr_d   = wr_addr_q;
    shift_d     = shift_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    din_d       = din_q;
    sat_d       = sat_q;

    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          wr_addr_d   = cfg_base_addr;
          remaining_d = cfg_len;
          shift_d     = cfg_shift;
          sat_d       = '0;
          state_d     = (cfg_len != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (xfer) begin
          we_d        = 1'b1;
          addr_d      = wr_addr_q;
          din_d       = DATA_WIDTH'(rq_result);
          wr_addr_d   = wr_addr_q + SRAM_ADDR_WIDTH'(1);
          remaining_d = remaining_q - SRAM_ADDR_WIDTH'(1);
          if (rq_sat && (sat_q != 16'hFFFF)) begin
            sat_d = sat_q + 16'd1;
          end
          if (remaining_q == SRAM_ADDR_WIDTH'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      wr_addr_q   <= '0;
      shift_q     <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      sat_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      wr_addr_q   <= wr_addr_d;
      shift_q     <= shift_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      sat_q       <= sat_d;
    end
  end

endmodule

// File: tb/tb_vec_writeback.sv
// Directed bench for vec_writeback: table of whole jobs plus hand-written
// sequences for backpressure, zero length, ignored start and mid-job reset.
module tb_vec_writeback;

  logic        clk;
  logic        rst;
  logic        cfg_start;
  logic [9:0]  cfg_base_addr;
  logic [9:0]  cfg_len;
  logic [4:0]  cfg_shift;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        sram_we;
  logic [9:0]  sram_addr;
  logic [7:0]  sram_din;
  logic        busy;
  logic        done;
  logic [15:0] sat_count;

  vec_writeback #(
    .SRAM_ADDR_WIDTH (10),
    .DATA_WIDTH      (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_base_addr (cfg_base_addr),
    .cfg_len       (cfg_len),
    .cfg_shift     (cfg_shift),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .sram_we       (sram_we),
    .sram_addr     (sram_addr),
    .sram_din      (sram_din),
    .busy          (busy),
    .done          (done),
    .sat_count     (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  base;
    int          len;
    logic [4:0]  shift;
    logic [31:0] data [4];
    logic [7:0]  exp  [4];
    logic [15:0] sat;
  } job_t;

  job_t jobs [4];
  int   n_vec;
  int   n_err;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_job(input logic [9:0] base, input logic [9:0] len, input logic [4:0] sh);
    cfg_base_addr = base;
    cfg_len       = len;
    cfg_shift     = sh;
    cfg_start     = 1'b1;
    step();
    cfg_start     = 1'b0;
  endtask

  task automatic run_job(input int j);
    logic [9:0] ea;
    start_job(jobs[j].base, 10'(jobs[j].len), jobs[j].shift);
    chk($sformatf("job%0d busy", j), 32'(busy), 32'd1);
    chk($sformatf("job%0d in_ready", j), 32'(in_ready), 32'd1);
    for (int k = 0; k < jobs[j].len; k++) begin
      in_data  = jobs[j].data[k];
      in_valid = 1'b1;
      step();
      ea = jobs[j].base + 10'(k);
      chk($sformatf("job%0d we[%0d]", j, k), 32'(sram_we), 32'd1);
      chk($sformatf("job%0d addr[%0d]", j, k), 32'(sram_addr), 32'(ea));
      chk($sformatf("job%0d din[%0d]", j, k), 32'(sram_din), 32'(jobs[j].exp[k]));
      chk($sformatf("job%0d done[%0d]", j, k), 32'(done), (k == jobs[j].len - 1) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    chk($sformatf("job%0d sat_count", j), 32'(sat_count), 32'(jobs[j].sat));
    chk($sformatf("job%0d in_ready at done", j), 32'(in_ready), 32'd0);
    step();
    chk($sformatf("job%0d busy after", j), 32'(busy), 32'd0);
    chk($sformatf("job%0d we after", j), 32'(sram_we), 32'd0);
    chk($sformatf("job%0d sat held", j), 32'(sat_count), 32'(jobs[j].sat));
  endtask

  initial begin
    logic       pat [6];
    logic [31:0] bp_data [3];
    int         rem;
    int         nx;
    logic       exp_x;

    n_vec = 0;
    n_err = 0;

    jobs[0].base = 10'h010; jobs[0].len = 4; jobs[0].shift = 5'd0; jobs[0].sat = 16'd0;
    jobs[0].data = '{32'd1, 32'hFFFF_FFFF, 32'd127, 32'hFFFF_FF80};
    jobs[0].exp  = '{8'h01, 8'hFF, 8'h7F, 8'h80};
    // -24 + 8 = -16, and -16 >>> 4 = -1; +/-40000 saturate.
    jobs[1].base = 10'h020; jobs[1].len = 4; jobs[1].shift = 5'd4; jobs[1].sat = 16'd2;
    jobs[1].data = '{32'd24, -32'sd24, 32'd40000, -32'sd40000};
    jobs[1].exp  = '{8'h02, 8'hFF, 8'h7F, 8'h80};
    // Wraps past the top address; 255 rounds to 128 and saturates.
    jobs[2].base = 10'h3FE; jobs[2].len = 3; jobs[2].shift = 5'd1; jobs[2].sat = 16'd1;
    jobs[2].data = '{32'd5, -32'sd5, 32'd255, 32'd0};
    jobs[2].exp  = '{8'h03, 8'hFE, 8'h7F, 8'h00};
    // Extreme shifts: bias on INT32_MAX needs the 33rd bit.
    jobs[3].base = 10'h100; jobs[3].len = 3; jobs[3].shift = 5'd31; jobs[3].sat = 16'd0;
    jobs[3].data = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'd0};
    jobs[3].exp  = '{8'h01, 8'hFF, 8'h00, 8'h00};

    rst = 1'b1; cfg_start = 1'b0; cfg_base_addr = '0; cfg_len = '0; cfg_shift = '0;
    in_data = '0; in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset we", 32'(sram_we), 32'd0);
    chk("reset addr", 32'(sram_addr), 32'd0);
    chk("reset din", 32'(sram_din), 32'd0);
    chk("reset sat", 32'(sat_count), 32'd0);

    for (int j = 0; j < 4; j++) run_job(j);

    // Shift 1 on INT32_MAX: (2^31 - 1 + 1) >>> 1 = 2^30, saturates.
    start_job(10'h000, 10'd1, 5'd1);
    in_data = 32'h7FFF_FFFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ovf din", 32'(sram_din), 32'h7F);
    chk("ovf sat", 32'(sat_count), 32'd1);
    step();

    // Backpressure with gaps.
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bp_data = '{32'd10, 32'd20, 32'd30};
    start_job(10'h050, 10'd3, 5'd0);
    rem = 3;
    nx  = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = pat[i];
      in_data  = bp_data[nx < 3 ? nx : 2];
      chk($sformatf("bp in_ready[%0d]", i), 32'(in_ready), (rem != 0) ? 32'd1 : 32'd0);
      exp_x = pat[i] && (rem != 0);
      step();
      chk($sformatf("bp we[%0d]", i), 32'(sram_we), 32'(exp_x));
      if (exp_x) begin
        chk($sformatf("bp addr[%0d]", i), 32'(sram_addr), 32'h050 + 32'(nx));
        chk($sformatf("bp din[%0d]", i), 32'(sram_din), bp_data[nx]);
        nx++;
        rem--;
      end
    end
    in_valid = 1'b0;
    chk("bp done", 32'(done), 32'd1);
    chk("bp in_ready after last", 32'(in_ready), 32'd0);
    step();
    chk("bp idle", 32'(busy), 32'd0);

    // Zero length job.
    start_job(10'h123, 10'd0, 5'd0);
    chk("zero done", 32'(done), 32'd1);
    chk("zero we", 32'(sram_we), 32'd0);
    chk("zero sat cleared", 32'(sat_count), 32'd0);
    step();
    chk("zero idle", 32'(busy), 32'd0);
    chk("zero we after", 32'(sram_we), 32'd0);

    // Start during RUN is ignored; reset abandons the job.
    start_job(10'h200, 10'd5, 5'd0);
    cfg_start = 1'b1; cfg_base_addr = 10'h300; cfg_len = 10'd1;
    in_data = 32'd1; in_valid = 1'b1;
    step();
    cfg_start = 1'b0;
    chk("ign addr0", 32'(sram_addr), 32'h200);
    in_data = 32'd2;
    step();
    chk("ign addr1", 32'(sram_addr), 32'h201);
    chk("ign din1", 32'(sram_din), 32'h02);
    chk("ign done", 32'(done), 32'd0);
    chk("ign in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst we", 32'(sram_we), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst addr", 32'(sram_addr), 32'd0);
    step();
    chk("rst no write", 32'(sram_we), 32'd0);
    run_job(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
